// File: rtl/wb_boot_sequencer_if.sv
// Wishbone classic single-cycle bus between the boot sequencer (master)
// and the downstream register slave.
interface wb_boot_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W  = DATA_W / 8
);
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [SEL_W-1:0]  wb_sel_o;
  logic [ADDR_W-1:0] wb_adr_o;
  logic [DATA_W-1:0] wb_dat_o;
  logic [DATA_W-1:0] wb_dat_i;
  logic              wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/wb_boot_sequencer.sv
// Replays an external command table onto a Wishbone master port after start_i,
// with read capture, per-transaction ack timeout, inter-command gap and looping.
module wb_boot_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SEL_W      = DATA_W / 8,
  parameter int N_CMDS     = 16,
  parameter int IDX_W      = 4,
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT    = 255,
  parameter int LOOP       = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  output logic [IDX_W-1:0]  cmd_idx_o,
  input  logic              cmd_we_i,
  input  logic [SEL_W-1:0]  cmd_sel_i,
  input  logic [ADDR_W-1:0] cmd_adr_i,
  input  logic [DATA_W-1:0] cmd_dat_i,
  wb_boot_sequencer_if.master wb,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [IDX_W-1:0]  err_idx_o,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] BUS   = 3'd2;
  localparam logic [2:0] GAP   = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;

  localparam int TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0;
  localparam int GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [IDX_W-1:0]  err_idx_q, err_idx_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              adv;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    done_d    = done_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    rd_d      = rd_q;
    adv       = 1'b0;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          idx_d     = '0;
          done_d    = 1'b0;
          err_d     = 1'b0;
          err_idx_d = '0;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        we_d    = cmd_we_i;
        sel_d   = cmd_sel_i;
        adr_d   = cmd_adr_i;
        dat_d   = cmd_dat_i;
        cnt_d   = '0;
        cyc_d   = 1'b1;
        state_d = BUS;
      end
      BUS: begin
        // Ack is tested first so an ack on the timeout cycle still completes.
        if (wb.wb_ack_i) begin
          cyc_d = 1'b0;
          if (!we_q) rd_d = wb.wb_dat_i;
          if (GAP_CYCLES > 1) begin
            gap_d   = '0;
            state_d = GAP;
          end else begin
            adv = 1'b1;
          end
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          cyc_d     = 1'b0;
          err_d     = 1'b1;
          err_idx_d = idx_q;
          state_d   = ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        // FETCH is itself an idle bus cycle, so GAP holds GAP_CYCLES-1 cycles
        // to give exactly GAP_CYCLES low cycles between strobes.
        if (gap_q == GAP_W'(GAP_LAST)) adv = 1'b1;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (adv) begin
      if (idx_q != IDX_W'(N_CMDS - 1)) begin
        idx_d   = idx_q + 1'b1;
        state_d = FETCH;
      end else if (LOOP != 0) begin
        idx_d   = '0;
        state_d = FETCH;
      end else begin
        done_d  = 1'b1;
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      rd_q      <= rd_d;
    end
  end

  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;

  assign cmd_idx_o = idx_q;
  assign busy_o    = (state_q == FETCH) || (state_q == BUS) || (state_q == GAP);
  assign done_o    = done_q;
  assign error_o   = err_q;
  assign err_idx_o = err_idx_q;
  assign rd_data_o = rd_q;

endmodule

// File: tb/tb_wb_boot_sequencer.sv
// Bench for wb_boot_sequencer: a 4-entry one-shot instance (A) and a
// 3-entry looping instance with gap (B), checked against expected-transaction queues.
module tb_wb_boot_sequencer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- DUT A: N_CMDS=4, GAP=0, TIMEOUT=8, LOOP=0
  logic          start_a;
  logic [3:0]    idx_a;
  logic          cmd_we_a;
  logic [SW-1:0] cmd_sel_a;
  logic [AW-1:0] cmd_adr_a;
  logic [DW-1:0] cmd_dat_a;
  logic          busy_a, done_a, err_a;
  logic [3:0]    erridx_a;
  logic [DW-1:0] rd_a;

  logic [3:0]    tab_we;
  logic [SW-1:0] tab_sel [4];
  logic [AW-1:0] tab_adr [4];
  logic [DW-1:0] tab_dat [4];

  assign cmd_we_a  = tab_we[idx_a[1:0]];
  assign cmd_sel_a = tab_sel[idx_a[1:0]];
  assign cmd_adr_a = tab_adr[idx_a[1:0]];
  assign cmd_dat_a = tab_dat[idx_a[1:0]];

  wb_boot_sequencer_if #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW)) wb_a ();

  wb_boot_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .N_CMDS(4), .IDX_W(4),
    .GAP_CYCLES(0), .TIMEOUT(8), .LOOP(0)
  ) dut_a (
    .clk(clk), .reset(rst), .start_i(start_a), .cmd_idx_o(idx_a),
    .cmd_we_i(cmd_we_a), .cmd_sel_i(cmd_sel_a), .cmd_adr_i(cmd_adr_a), .cmd_dat_i(cmd_dat_a),
    .wb(wb_a), .busy_o(busy_a), .done_o(done_a), .error_o(err_a),
    .err_idx_o(erridx_a), .rd_data_o(rd_a)
  );

  // ---------------- DUT B: N_CMDS=3, GAP=2, LOOP=1
  logic          start_b;
  logic [1:0]    idx_b;
  logic [AW-1:0] cmd_adr_b;
  logic          busy_b, done_b, err_b;
  logic [1:0]    erridx_b;
  logic [DW-1:0] rd_b;

  assign cmd_adr_b = 32'h2000 + {28'd0, idx_b, 2'b00};

  wb_boot_sequencer_if #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW)) wb_b ();

  wb_boot_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .N_CMDS(3), .IDX_W(2),
    .GAP_CYCLES(2), .TIMEOUT(8), .LOOP(1)
  ) dut_b (
    .clk(clk), .reset(rst), .start_i(start_b), .cmd_idx_o(idx_b),
    .cmd_we_i(1'b1), .cmd_sel_i(4'hF), .cmd_adr_i(cmd_adr_b), .cmd_dat_i(cmd_adr_b),
    .wb(wb_b), .busy_o(busy_b), .done_o(done_b), .error_o(err_b),
    .err_idx_o(erridx_b), .rd_data_o(rd_b)
  );

  // ---------------- slave models (drive on negedge)
  logic          nack_en;
  logic [AW-1:0] nack_adr;
  logic [DW-1:0] rd_val;
  int            acks_a = 0;

  initial begin
    wb_a.wb_ack_i = 1'b0;
    wb_a.wb_dat_i = '0;
    forever begin
      @(negedge clk);
      wb_a.wb_ack_i = wb_a.wb_stb_o && !(nack_en && (wb_a.wb_adr_o == nack_adr));
      wb_a.wb_dat_i = rd_val;
      if (wb_a.wb_ack_i) acks_a++;
    end
  end

  initial begin
    wb_b.wb_ack_i = 1'b0;
    wb_b.wb_dat_i = '0;
    forever begin
      @(negedge clk);
      wb_b.wb_ack_i = wb_b.wb_stb_o;
    end
  end

  // ---------------- scoreboards
  typedef struct packed {
    logic [3:0]    idx;
    logic          we;
    logic [SW-1:0] sel;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } txn_t;

  txn_t       exp_a[$];
  logic [1:0] exp_b[$];

  int   rises_a    = 0;
  int   run_a      = 0;
  int   last_len_a = 0;
  logic stb_prev_a = 1'b0;

  task automatic push_a(input int first, input int last);
    for (int i = first; i <= last; i++)
      exp_a.push_back('{idx: 4'(i), we: tab_we[i], sel: tab_sel[i], adr: tab_adr[i], dat: tab_dat[i]});
  endtask

  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      if (wb_a.wb_stb_o) begin
        if (!stb_prev_a) begin
          rises_a++;
          check("a_sb_nonempty", exp_a.size() != 0, 1);
          if (exp_a.size() != 0) begin
            t = exp_a.pop_front();
            check("a_idx", idx_a, t.idx);
            check("a_we", wb_a.wb_we_o, t.we);
            check("a_sel", wb_a.wb_sel_o, t.sel);
            check("a_adr", wb_a.wb_adr_o, t.adr);
            if (t.we) check("a_dat", wb_a.wb_dat_o, t.dat);
            check("a_cyc_with_stb", wb_a.wb_cyc_o, 1);
          end
        end
        run_a++;
      end else begin
        if (stb_prev_a) last_len_a = run_a;
        run_a = 0;
      end
      stb_prev_a = wb_a.wb_stb_o;
    end
  end

  logic stb_prev_b  = 1'b0;
  logic first_b     = 1'b1;
  logic done_b_seen = 1'b0;
  int   low_b       = 0;

  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (done_b) done_b_seen = 1'b1;
      if (wb_b.wb_stb_o && !stb_prev_b) begin
        if (exp_b.size() != 0) begin
          e = exp_b.pop_front();
          check("b_idx", idx_b, e);
          if (!first_b) check("b_gap_low_cycles", low_b, 2);
          first_b = 1'b0;
        end
        low_b = 0;
      end else if (!wb_b.wb_stb_o) begin
        low_b++;
      end
      stb_prev_b = wb_b.wb_stb_o;
    end
  end

  // ---------------- helpers
  task automatic pulse_start_a();
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    check("a_busy_after_start", busy_a, 1);
    check("a_done_cleared", done_a, 0);
    check("a_err_cleared", err_a, 0);
    check("a_erridx_cleared", erridx_a, 0);
    check("a_idx_zero", idx_a, 0);
    check("a_no_stb_in_fetch", wb_a.wb_stb_o, 0);
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    logic got;
    logic prev_busy;
    got = 1'b0;
    prev_busy = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done_a) begin
        got = 1'b1;
        break;
      end
      prev_busy = busy_a;
    end
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_busy_before_done"}, prev_busy, 1);
    check({tag, "_busy_falls_with_done"}, busy_a, 0);
    check({tag, "_stb_low_at_done"}, wb_a.wb_stb_o, 0);
    check({tag, "_acks"}, acks_a, 4);
  endtask

  // ---------------- main sequence
  initial begin
    int r0;
    logic got;
    tab_we     = 4'b1011;
    tab_sel[0] = 4'hF; tab_sel[1] = 4'h3; tab_sel[2] = 4'hF; tab_sel[3] = 4'hC;
    tab_adr[0] = 32'h0000_1000; tab_adr[1] = 32'h0000_1004;
    tab_adr[2] = 32'h0000_1008; tab_adr[3] = 32'h0000_100C;
    tab_dat[0] = 32'hA5A5_0000; tab_dat[1] = 32'h0000_0011;
    tab_dat[2] = 32'h5555_AAAA; tab_dat[3] = 32'hCAFE_0003;
    start_a  = 1'b0;
    start_b  = 1'b0;
    nack_en  = 1'b0;
    nack_adr = tab_adr[1];
    rd_val   = 32'hDEAD_BEEF;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stb", wb_a.wb_stb_o, 0);
    check("rst_cyc", wb_a.wb_cyc_o, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_error", err_a, 0);
    check("rst_err_idx", erridx_a, 0);
    check("rst_rd_data", rd_a, 0);
    check("rst_idx", idx_a, 0);
    check("rst_adr", wb_a.wb_adr_o, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_stb", rises_a, 0);

    // Run 1: all entries, entry 2 a read; B starts looping alongside.
    push_a(0, 3);
    for (int k = 0; k < 7; k++) exp_b.push_back(2'(k % 3));
    acks_a  = 0;
    start_a = 1'b1;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    check("lat_stb_low_first_edge", wb_a.wb_stb_o, 0);
    check("lat_busy", busy_a, 1);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    @(posedge clk);
    #1;
    check("lat_stb_second_edge", wb_a.wb_stb_o, 1);
    // start_i while entry 1 is on the bus must be ignored
    for (int i = 0; i < 20 && !(idx_a == 4'd1 && wb_a.wb_stb_o); i++) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a("run1");
    check("run1_sb_drained", exp_a.size(), 0);
    check("run1_rd_data", rd_a, 32'hDEAD_BEEF);

    // Run 2: restart from DONE, entry 1 never acked -> timeout.
    push_a(0, 1);
    acks_a  = 0;
    nack_en = 1'b1;
    rd_val  = 32'h0BAD_0BAD;
    pulse_start_a();
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (err_a) begin
        got = 1'b1;
        break;
      end
    end
    check("to_error_seen", got, 1);
    check("to_err_idx", erridx_a, 1);
    check("to_stb_dropped", wb_a.wb_stb_o, 0);
    check("to_busy", busy_a, 0);
    check("to_done", done_a, 0);
    @(negedge clk);
    check("to_stb_len", last_len_a, 8);
    repeat (6) @(negedge clk);
    check("to_no_next_stb", exp_a.size(), 0);
    check("to_rd_unchanged", rd_a, 32'hDEAD_BEEF);
    check("to_acks", acks_a, 1);

    // Run 3: restart from ERR with a new read value.
    push_a(0, 3);
    acks_a  = 0;
    nack_en = 1'b0;
    rd_val  = 32'h1234_5678;
    pulse_start_a();
    wait_done_a("run3");
    check("run3_rd_data", rd_a, 32'h1234_5678);

    // Looping instance
    for (int i = 0; i < 60 && exp_b.size() != 0; i++) @(negedge clk);
    check("b_sb_drained", exp_b.size(), 0);
    check("b_done_never", done_b_seen, 0);
    check("b_busy_looping", busy_b, 1);
    check("b_no_error", err_b, 0);

    // Reset in the middle of a bus cycle.
    nack_en  = 1'b1;
    nack_adr = tab_adr[0];
    push_a(0, 0);
    pulse_start_a();
    @(posedge clk);
    #1;
    check("mid_stb_high", wb_a.wb_stb_o, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_stb", wb_a.wb_stb_o, 0);
    check("mid_rst_cyc", wb_a.wb_cyc_o, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_b_stb", wb_b.wb_stb_o, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_a.delete();
    exp_b.delete();
    r0 = rises_a;
    repeat (8) @(negedge clk);
    check("post_rst_no_bus", rises_a - r0, 0);
    check("post_rst_busy", busy_a, 0);
    check("post_rst_idx", idx_a, 0);
    check("post_rst_done", done_a, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
